// File: rtl/sc_demap_pkg.sv
// Shared types and the bin-to-subcarrier mapping for the subcarrier demapper.
// sc_pos is the single source of truth for which FFT bins are occupied.
package sc_demap_pkg;

    localparam int CPLX_DW = 16;

    typedef struct packed {
        logic [CPLX_DW-1:0] imag;
        logic [CPLX_DW-1:0] re;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    // Returns the output position of bin k, or -1 when the bin carries no subcarrier.
    function automatic int sc_pos(input int k, input logic dc, input logic ord,
                                  input int fft, input int sc);
        int h;
        int d;
        h = sc / 2;
        d = dc ? 0 : 1;
        if (k >= d && k <= h - 1 + d) begin
            return ord ? (h + k - d) : (k - d);
        end else if (k >= fft - h && k < fft) begin
            return ord ? (k - (fft - h)) : (h + k - (fft - h));
        end
        return -1;
    endfunction

endpackage

// File: rtl/sc_demap_mc_if.sv
// Bus bundle for the demapper: FFT input stream, config, demapped output stream and status.
// Output handshake: a beat transfers on a cycle where dout_valid and dout_ready are both 1;
// while dout_valid=1 and dout_ready=0 every dout_* field holds its value.
interface sc_demap_mc_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int META_WIDTH = 28,
    parameter int IDX_W      = 12,
    parameter int BLK_W      = 3
);
    localparam int DW = NUM_CH * 2 * DATA_WIDTH;

    logic                  din_valid;
    logic                  din_sop;
    logic                  din_eop;
    logic [DW-1:0]         din_data;
    logic [META_WIDTH-1:0] din_meta;
    logic                  cfg_dc_enable;
    logic                  cfg_sc_ord;
    logic                  dout_ready;
    logic                  dout_valid;
    logic                  dout_sop;
    logic                  dout_eop;
    logic [DW-1:0]         dout_data;
    logic [IDX_W-1:0]      dout_index;
    logic [META_WIDTH-1:0] dout_meta;
    logic [BLK_W-1:0]      bloc_used;
    logic [31:0]           overflow_cnt;
    logic [31:0]           runt_cnt;

    modport master (
        output din_valid, din_sop, din_eop, din_data, din_meta,
               cfg_dc_enable, cfg_sc_ord, dout_ready,
        input  dout_valid, dout_sop, dout_eop, dout_data, dout_index, dout_meta,
               bloc_used, overflow_cnt, runt_cnt
    );

    modport slave (
        input  din_valid, din_sop, din_eop, din_data, din_meta,
               cfg_dc_enable, cfg_sc_ord, dout_ready,
        output dout_valid, dout_sop, dout_eop, dout_data, dout_index, dout_meta,
               bloc_used, overflow_cnt, runt_cnt
    );

endinterface

// File: rtl/sc_demap_sdpram.sv
// Simple dual-port RAM holding all symbol blocks; one write and one registered read per cycle.
module sc_demap_sdpram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sc_demap_mc.sv
// Multi-channel subcarrier demapper: writes occupied bins of each symbol into a block buffer
// in output order, then streams committed blocks through a 2-entry skid FIFO.
module sc_demap_mc
    import sc_demap_pkg::*;
#(
    parameter int FFT_SIZE   = 4096,
    parameter int SC_NUM     = 3276,
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int META_WIDTH = 28,
    parameter int BLOCK_QTY  = 4,
    parameter int IDX_W      = $clog2(FFT_SIZE),
    parameter int BLK_W      = $clog2(BLOCK_QTY + 1)
) (
    input  logic      clk,
    input  logic      rst,
    sc_demap_mc_if.slave bus,
    output wr_state_e dbg_state_o
);

    localparam int DW    = NUM_CH * 2 * DATA_WIDTH;
    localparam int DEPTH = BLOCK_QTY * SC_NUM;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = $clog2(BLOCK_QTY);
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_SC  = IDX_W'(SC_NUM - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_QTY - 1);

    wr_state_e             state_q, state_d;
    logic [IDX_W-1:0]      bin_q, cur_bin;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic                  wr_dc_q, wr_ord_q, cur_dc, cur_ord;
    logic [META_WIDTH-1:0] meta_q [BLOCK_QTY];
    logic [31:0]           ovf_q, runt_q;
    logic                  writing, cap, commit, runt_inc, ovf_inc, start_ok, wr_en;
    logic [AW-1:0]         wr_addr;
    int                    pos;

    logic [BLK_W-1:0]      bloc_used_q;
    logic [1:0]            ahead_q;
    logic [PTR_W-1:0]      iss_ptr_q;
    logic [IDX_W-1:0]      iss_idx_q, rd_idx_q, head_idx;
    logic                  rd_pend_q;
    logic [META_WIDTH-1:0] rd_meta_q;
    logic [DW-1:0]         rdata;
    logic [DW-1:0]         f_data_q [2];
    logic [IDX_W-1:0]      f_idx_q  [2];
    logic [META_WIDTH-1:0] f_meta_q [2];
    logic [1:0]            f_cnt_q;
    logic                  f_head_q, tail, pop, rel_blk, issue, last_iss;
    logic [AW-1:0]         rd_addr;

    assign start_ok = (bloc_used_q < BLK_W'(BLOCK_QTY));

    always_comb begin
        state_d  = state_q;
        writing  = 1'b0;
        cap      = 1'b0;
        commit   = 1'b0;
        runt_inc = 1'b0;
        ovf_inc  = 1'b0;
        cur_bin  = bus.din_sop ? '0 : bin_q;
        cur_dc   = bus.din_sop ? bus.cfg_dc_enable : wr_dc_q;
        cur_ord  = bus.din_sop ? bus.cfg_sc_ord : wr_ord_q;
        pos      = sc_pos(int'(cur_bin), cur_dc, cur_ord, FFT_SIZE, SC_NUM);
        if (bus.din_valid) begin
            if (bus.din_sop) begin
                // A sop mid-symbol restarts in the buffer already reserved for it.
                if (state_q == WRITE) begin
                    runt_inc = 1'b1;
                    writing  = 1'b1;
                    cap      = 1'b1;
                end else if (start_ok) begin
                    writing  = 1'b1;
                    cap      = 1'b1;
                end else begin
                    ovf_inc  = 1'b1;
                    state_d  = DROP;
                end
            end else if (state_q == WRITE) begin
                writing = 1'b1;
            end else if (state_q == DROP && bus.din_eop) begin
                state_d = IDLE;
            end
            if (writing) begin
                state_d = WRITE;
                if (cur_bin == LAST_BIN) begin
                    state_d  = IDLE;
                    commit   = bus.din_eop;
                    runt_inc = runt_inc | ~bus.din_eop;
                end else if (bus.din_eop) begin
                    state_d  = IDLE;
                    runt_inc = 1'b1;
                end
            end
        end
        wr_en   = writing && (pos >= 0);
        wr_addr = AW'(int'(wr_ptr_q) * SC_NUM + pos);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            wr_ptr_q <= '0;
            wr_dc_q  <= 1'b0;
            wr_ord_q <= 1'b0;
            ovf_q    <= '0;
            runt_q   <= '0;
            for (int b = 0; b < BLOCK_QTY; b++) meta_q[b] <= '0;
        end else begin
            state_q <= state_d;
            if (bus.din_valid) bin_q <= cur_bin + 1'b1;
            if (cap) begin
                wr_dc_q          <= cur_dc;
                wr_ord_q         <= cur_ord;
                meta_q[wr_ptr_q] <= bus.din_meta;
            end
            if (commit) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (ovf_inc && ovf_q != '1) ovf_q <= ovf_q + 1'b1;
            if (runt_inc && runt_q != '1) runt_q <= runt_q + 1'b1;
        end
    end

    // ahead_q counts committed blocks whose reads are all issued but whose eop is not yet accepted.
    always_comb begin
        pop      = (f_cnt_q != 2'd0) && bus.dout_ready;
        head_idx = f_idx_q[f_head_q];
        rel_blk  = pop && (head_idx == LAST_SC);
        issue    = (int'(bloc_used_q) > int'(ahead_q)) &&
                   ((int'(f_cnt_q) + int'(rd_pend_q) - int'(pop)) < 2);
        last_iss = issue && (iss_idx_q == LAST_SC);
        rd_addr  = AW'(int'(iss_ptr_q) * SC_NUM + int'(iss_idx_q));
        tail     = f_head_q ^ (f_cnt_q == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bloc_used_q <= '0;
            ahead_q     <= '0;
            iss_ptr_q   <= '0;
            iss_idx_q   <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            rd_meta_q   <= '0;
            f_cnt_q     <= '0;
            f_head_q    <= 1'b0;
            for (int e = 0; e < 2; e++) begin
                f_data_q[e] <= '0;
                f_idx_q[e]  <= '0;
                f_meta_q[e] <= '0;
            end
        end else begin
            bloc_used_q <= bloc_used_q + BLK_W'(commit) - BLK_W'(rel_blk);
            ahead_q     <= ahead_q + 2'(last_iss) - 2'(rel_blk);
            if (issue) begin
                iss_idx_q <= last_iss ? '0 : iss_idx_q + 1'b1;
                if (last_iss) iss_ptr_q <= (iss_ptr_q == LAST_PTR) ? '0 : iss_ptr_q + 1'b1;
            end
            rd_pend_q <= issue;
            rd_idx_q  <= iss_idx_q;
            rd_meta_q <= meta_q[iss_ptr_q];
            if (rd_pend_q) begin
                f_data_q[tail] <= rdata;
                f_idx_q[tail]  <= rd_idx_q;
                f_meta_q[tail] <= rd_meta_q;
            end
            if (pop) f_head_q <= ~f_head_q;
            f_cnt_q <= f_cnt_q + 2'(rd_pend_q) - 2'(pop);
        end
    end

    sc_demap_sdpram #(.DEPTH(DEPTH), .WIDTH(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (bus.din_data),
        .re_i    (issue),
        .raddr_i (rd_addr),
        .rdata_o (rdata)
    );

    assign bus.dout_valid   = (f_cnt_q != 2'd0);
    assign bus.dout_sop     = bus.dout_valid && (head_idx == '0);
    assign bus.dout_eop     = bus.dout_valid && (head_idx == LAST_SC);
    assign bus.dout_data    = f_data_q[f_head_q];
    assign bus.dout_index   = head_idx;
    assign bus.dout_meta    = f_meta_q[f_head_q];
    assign bus.bloc_used    = bloc_used_q;
    assign bus.overflow_cnt = ovf_q;
    assign bus.runt_cnt     = runt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sc_demap_mc.sv
// Directed bench for sc_demap_mc at FFT_SIZE=16, SC_NUM=12, NUM_CH=2, BLOCK_QTY=2.
// Sample word per channel: real = {ch, sym[6:0], bin[7:0]}, imag = ~real.
module tb_sc_demap_mc;
  import sc_demap_pkg::*;

  localparam int FFT = 16;
  localparam int SC = 12;
  localparam int IDX_W = 4;
  localparam int MW = 28;
  localparam int DW = 64;
  localparam int EW = MW + DW + IDX_W;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 1;
  bit mon_en = 1'b1;
  int eop_cyc = 0;
  int first_sop_cyc = -1;
  wr_state_e dbg_state;
  logic [EW-1:0] exp_q[$];

  // Expected bin at each output position, row = {dc, ord}.
  int tab[4][12] = '{
    '{1, 2, 3, 4, 5, 6, 10, 11, 12, 13, 14, 15},
    '{10, 11, 12, 13, 14, 15, 1, 2, 3, 4, 5, 6},
    '{0, 1, 2, 3, 4, 5, 10, 11, 12, 13, 14, 15},
    '{10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4, 5}
  };

  sc_demap_mc_if #(.NUM_CH(2), .DATA_WIDTH(16), .META_WIDTH(MW), .IDX_W(IDX_W), .BLK_W(2)) ifc ();

  sc_demap_mc #(
    .FFT_SIZE(FFT), .SC_NUM(SC), .NUM_CH(2), .DATA_WIDTH(16), .META_WIDTH(MW), .BLOCK_QTY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] mk_data(input int sym, input int bin);
    cplx_t s;
    logic [DW-1:0] d;
    d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      s.re = {ch[0], sym[6:0], bin[7:0]};
      s.imag = ~s.re;
      d[ch*32 +: 32] = s;
    end
    return d;
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifc.din_valid = 1'b0;
      ifc.din_sop = 1'b0;
      ifc.din_eop = 1'b0;
    end
  endtask

  task automatic send(input int sym, input logic [MW-1:0] meta, input logic dc, input logic ord,
                      input int last_bin, input bit expect_out, input bit wait_free);
    int n;
    for (int b = 0; b <= last_bin; b++) begin
      @(posedge clk); #1;
      if (b == 0 && wait_free) begin
        ifc.din_valid = 1'b0;
        ifc.din_sop = 1'b0;
        ifc.din_eop = 1'b0;
        n = 0;
        while (ifc.bloc_used == 2 && n < BUDGET) begin
          @(posedge clk); #1;
          n++;
        end
        chk("free_wait", (n < BUDGET), 1);
      end
      ifc.din_valid = 1'b1;
      ifc.din_sop = (b == 0);
      ifc.din_eop = (b == last_bin);
      ifc.din_data = mk_data(sym, b);
      ifc.din_meta = meta;
      ifc.cfg_dc_enable = dc;
      ifc.cfg_sc_ord = ord;
      if (b == last_bin) eop_cyc = cyc;
    end
    if (expect_out)
      for (int p = 0; p < SC; p++)
        exp_q.push_back({meta, mk_data(sym, tab[int'({dc, ord})][p]), 4'(p)});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ready generator
  initial begin
    ifc.dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ifc.dout_ready = 1'b0;
        1: ifc.dout_ready = 1'b1;
        default: ifc.dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard / monitor
  initial begin
    logic [EW-1:0] cur, held, exp_v;
    bit held_v;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        held_v = 1'b0;
      end else begin
        cur = {ifc.dout_meta, ifc.dout_data, ifc.dout_index};
        if (held_v) begin
          chk("hold_valid", ifc.dout_valid, 1);
          chk("hold_beat", cur, held);
        end
        if (ifc.dout_valid && ifc.dout_ready) begin
          exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          chk("beat", cur, exp_v);
          chk("sop", ifc.dout_sop, (exp_v[IDX_W-1:0] == 0));
          chk("eop", ifc.dout_eop, (exp_v[IDX_W-1:0] == SC - 1));
          if (ifc.dout_sop && first_sop_cyc < 0) first_sop_cyc = cyc;
          held_v = 1'b0;
        end else if (ifc.dout_valid) begin
          held = cur;
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // directed sequence
  initial begin
    int n;
    ifc.din_valid = 1'b0;
    ifc.din_sop = 1'b0;
    ifc.din_eop = 1'b0;
    ifc.din_data = '0;
    ifc.din_meta = '0;
    ifc.cfg_dc_enable = 1'b0;
    ifc.cfg_sc_ord = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", ifc.dout_valid, 0);
    chk("rst_bloc", ifc.bloc_used, 0);
    chk("rst_ovf", ifc.overflow_cnt, 0);
    chk("rst_runt", ifc.runt_cnt, 0);
    chk("rst_state", dbg_state, IDLE);

    // basic order with latency
    rdy_mode = 1;
    idle(2);
    first_sop_cyc = -1;
    send(0, 28'h1, 1'b1, 1'b0, 15, 1'b1, 1'b0);
    @(negedge clk);
    chk("bloc_at_eop", ifc.bloc_used, 0);
    idle(1);
    @(negedge clk);
    chk("bloc_after_eop", ifc.bloc_used, 1);
    wait_drain("basic_drain");
    chk("latency", first_sop_cyc - eop_cyc, 3);
    chk("basic_bloc", ifc.bloc_used, 0);

    // dc off, negative first
    send(1, 28'h2, 1'b0, 1'b1, 15, 1'b1, 1'b0);
    idle(1);
    wait_drain("swap_drain");

    // overflow with output stalled
    rdy_mode = 0;
    idle(2);
    send(2, 28'hA, 1'b1, 1'b0, 15, 1'b1, 1'b0);
    send(3, 28'hB, 1'b1, 1'b0, 15, 1'b1, 1'b0);
    send(4, 28'hC, 1'b1, 1'b0, 15, 1'b0, 1'b0);
    idle(4);
    chk("ovf_bloc", ifc.bloc_used, 2);
    chk("ovf_cnt", ifc.overflow_cnt, 1);
    chk("ovf_runt", ifc.runt_cnt, 0);
    chk("ovf_head_meta", ifc.dout_meta, 28'hA);
    chk("ovf_head_sop", ifc.dout_sop, 1);
    rdy_mode = 1;
    wait_drain("ovf_drain");
    chk("ovf_bloc_end", ifc.bloc_used, 0);

    // random ready, all dc/ord combinations
    rdy_mode = 2;
    for (int i = 0; i < 20; i++)
      send(10 + i, 28'h100 + i, i[1], i[0], 15, 1'b1, 1'b1);
    idle(1);
    wait_drain("rand_drain");
    rdy_mode = 1;
    idle(2);
    chk("rand_ovf", ifc.overflow_cnt, 1);
    chk("rand_bloc", ifc.bloc_used, 0);

    // runt then a good symbol
    send(40, 28'h77, 1'b1, 1'b0, 9, 1'b0, 1'b0);
    idle(6);
    chk("runt_cnt", ifc.runt_cnt, 1);
    chk("runt_bloc", ifc.bloc_used, 0);
    send(41, 28'h5, 1'b1, 1'b0, 15, 1'b1, 1'b0);
    idle(1);
    wait_drain("runt_next_drain");
    chk("runt_cnt_end", ifc.runt_cnt, 1);

    // reset while a block is being output
    send(42, 28'h9, 1'b0, 1'b0, 15, 1'b1, 1'b0);
    idle(1);
    n = 0;
    @(negedge clk);
    while (!(ifc.dout_valid && ifc.dout_index == 5) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("idx5_seen", (n < BUDGET), 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", ifc.dout_valid, 0);
    chk("mid_rst_bloc", ifc.bloc_used, 0);
    chk("mid_rst_ovf", ifc.overflow_cnt, 0);
    chk("mid_rst_runt", ifc.runt_cnt, 0);
    exp_q.delete();
    mon_en = 1'b1;
    send(43, 28'hC3, 1'b1, 1'b1, 15, 1'b1, 1'b0);
    idle(1);
    wait_drain("post_rst_drain");
    chk("post_rst_bloc", ifc.bloc_used, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
